// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter and sequencer between two single-beat requesters and a
// 32x8 synchronous memory; serialises reads/writes and returns done pulses.
module mem_bus_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDCAP  = 2'd2
    } state_t;

    state_t              state_q;
    logic                ptr_q;
    logic                sel_q;
    logic                we_q;
    logic                gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
    logic                mem_read_q, mem_write_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_data_q, rdata0_q, rdata1_q;

    logic                grant_s;
    logic                pick_s;
    logic                pick_we_s;
    logic [ADDR_W-1:0]   pick_addr_s;
    logic [DATA_W-1:0]   pick_wdata_s;

    // Winner selection: ptr_q names the favoured requester when both ask.
    always_comb begin
        grant_s = 1'b0;
        pick_s  = 1'b0;
        if (req0 && (!req1 || !ptr_q)) begin
            grant_s = 1'b1;
            pick_s  = 1'b0;
        end else if (req1) begin
            grant_s = 1'b1;
            pick_s  = 1'b1;
        end else begin
            grant_s = 1'b0;
            pick_s  = 1'b0;
        end
    end

    assign pick_we_s    = pick_s ? we1    : we0;
    assign pick_addr_s  = pick_s ? addr1  : addr0;
    assign pick_wdata_s = pick_s ? wdata1 : wdata0;

    // Sequencer FSM; every output is driven from a register here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            sel_q       <= 1'b0;
            we_q        <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_data_q  <= {DATA_W{1'b0}};
            rdata0_q    <= {DATA_W{1'b0}};
            rdata1_q    <= {DATA_W{1'b0}};
        end else begin
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_s) begin
                        gnt0_q      <= ~pick_s;
                        gnt1_q      <= pick_s;
                        mem_addr_q  <= pick_addr_s;
                        mem_data_q  <= pick_wdata_s;
                        mem_write_q <= pick_we_s;
                        mem_read_q  <= ~pick_we_s;
                        sel_q       <= pick_s;
                        we_q        <= pick_we_s;
                        ptr_q       <= ~pick_s;
                        busy_q      <= 1'b1;
                        state_q     <= ACCESS;
                    end else begin
                        state_q     <= IDLE;
                    end
                end
                ACCESS: begin
                    // The memory commits the write or latches read data on this edge.
                    if (we_q) begin
                        done0_q <= ~sel_q;
                        done1_q <= sel_q;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= RDCAP;
                    end
                end
                RDCAP: begin
                    if (sel_q) begin
                        rdata1_q <= mem_data_out;
                    end else begin
                        rdata0_q <= mem_data_out;
                    end
                    done0_q <= ~sel_q;
                    done1_q <= sel_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign busy        = busy_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a behavioural memory plus a
// round-robin/serial-bus reference model predicts grants, strobes and completions.
module tb_mem_bus_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;

    typedef struct {
        int            id;
        logic          we;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    req_v = 2'b00;
    logic [1:0]    we_v = 2'b00;
    logic [AW-1:0] addr_a [2];
    logic [DW-1:0] wd_a [2];
    logic [1:0]    gnt_v, done_v;
    logic [DW-1:0] rdata0, rdata1, mem_data_in;
    logic [DW-1:0] mem_data_out = 8'h00;
    logic [AW-1:0] mem_addr;
    logic          busy, mem_read, mem_write;
    logic [35:0]   outs;

    logic [DW-1:0] mem [32];
    logic [DW-1:0] ref_mem [32];
    logic [DW-1:0] rd_m [2];
    exp_t          q[$];
    int            glog[$];
    int            checks = 0;
    int            fails = 0;
    int            cyc = 0;
    int            ptr = 0;
    int            dn_cnt [2];
    logic          m_free = 1'b1;
    logic          prev_free = 1'b1;
    logic          snap_ok = 1'b0;
    logic [1:0]    s_req, s_we, eg;
    logic [AW-1:0] s_addr [2];
    logic [DW-1:0] s_wd [2];
    int            w;
    exp_t          e;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req_v[0]), .we0(we_v[0]), .addr0(addr_a[0]), .wdata0(wd_a[0]),
        .gnt0(gnt_v[0]), .done0(done_v[0]), .rdata0(rdata0),
        .req1(req_v[1]), .we1(we_v[1]), .addr1(addr_a[1]), .wdata1(wd_a[1]),
        .gnt1(gnt_v[1]), .done1(done_v[1]), .rdata1(rdata1),
        .busy(busy), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    assign outs = {gnt_v, done_v, busy, mem_read, mem_write, mem_addr, mem_data_in, rdata0, rdata1};

    always #5 clk = ~clk;

    // Synchronous 32x8 memory the arbiter drives.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_data_in;
        if (mem_read) mem_data_out <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Post one request and hold it until the grant is seen.
    task automatic do_op(input int n, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int k;
        we_v[n] = wr;
        addr_a[n] = a;
        wd_a[n] = d;
        req_v[n] = 1'b1;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!gnt_v[n] && k < 200);
        chk("grant_seen", gnt_v[n], 1'b1);
        req_v[n] = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while ((q.size() != 0 || !m_free || req_v != 2'b00) && k < 100);
        chk("drain_idle", {31'd0, m_free, q.size()}, {31'd0, 1'b1, 32'd0});
    endtask

    // Monitor: predicts each cycle's grant from last cycle's requests, then scores completions.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            ptr = 0;
            m_free = 1'b1;
            prev_free = 1'b1;
            snap_ok = 1'b0;
            rd_m[0] = 8'h00;
            rd_m[1] = 8'h00;
        end else begin
            eg = 2'b00;
            w = 0;
            if (snap_ok && prev_free && s_req != 2'b00) begin
                w = (s_req == 2'b11) ? ptr : (s_req[0] ? 0 : 1);
                eg[w] = 1'b1;
            end
            chk("grant", gnt_v, eg);
            if (eg != 2'b00) begin
                chk("strobes", {mem_write, mem_read}, s_we[w] ? 2'b10 : 2'b01);
                chk("mem_addr", mem_addr, s_addr[w]);
                chk("mem_data_in", mem_data_in, s_wd[w]);
                if (s_we[w]) begin
                    ref_mem[s_addr[w]] = s_wd[w];
                    e = '{w, 1'b1, 8'h00, cyc + 1};
                end else begin
                    e = '{w, 1'b0, ref_mem[s_addr[w]], cyc + 2};
                end
                q.push_back(e);
                m_free = 1'b0;
                ptr = 1 - w;
                glog.push_back(w);
            end else begin
                chk("strobes_off", {mem_write, mem_read}, 2'b00);
            end
            if (done_v[0]) dn_cnt[0]++;
            if (done_v[1]) dn_cnt[1]++;
            if (done_v != 2'b00) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", done_v, 2'b00);
                end else begin
                    e = q.pop_front();
                    chk("done_who", done_v, (e.id == 1) ? 2'b10 : 2'b01);
                    chk("done_cycle", cyc, e.due);
                    if (!e.we) rd_m[e.id] = e.data;
                    m_free = 1'b1;
                end
            end else if (q.size() != 0 && cyc >= q[0].due) begin
                chk("done_missing", done_v, (q[0].id == 1) ? 2'b10 : 2'b01);
                void'(q.pop_front());
                m_free = 1'b1;
            end
            chk("busy", busy, !m_free);
            chk("rdata0", rdata0, rd_m[0]);
            chk("rdata1", rdata1, rd_m[1]);
            s_req = req_v;
            s_we = we_v;
            s_addr[0] = addr_a[0];
            s_addr[1] = addr_a[1];
            s_wd[0] = wd_a[0];
            s_wd[1] = wd_a[1];
            prev_free = m_free;
            snap_ok = 1'b1;
        end
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        addr_a[0] = 5'd0;
        addr_a[1] = 5'd0;
        wd_a[0] = 8'h00;
        wd_a[1] = 8'h00;
        dn_cnt[0] = 0;
        dn_cnt[1] = 0;
        #12;
        chk("reset_outputs", outs, 36'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single write then read-back on requester 0.
        do_op(0, 1'b1, 5'd5, 8'hA5);
        wait_idle();
        do_op(0, 1'b0, 5'd5, 8'h00);
        wait_idle();
        chk("readback_a5", rdata0, 8'hA5);

        // Clear, fill with data=address, read everything back on requester 1.
        dn_cnt[1] = 0;
        for (int i = 0; i < 32; i++) do_op(1, 1'b1, 5'(i), 8'h00);
        wait_idle();
        chk("clear_dones", dn_cnt[1], 32);
        dn_cnt[1] = 0;
        for (int i = 0; i < 32; i++) do_op(1, 1'b1, 5'(i), 8'(i));
        wait_idle();
        chk("fill_dones", dn_cnt[1], 32);
        dn_cnt[1] = 0;
        for (int i = 0; i < 32; i++) begin
            do_op(1, 1'b0, 5'(i), 8'h00);
            wait_idle();
            chk("sweep_read", rdata1, 8'(i));
        end
        chk("read_dones", dn_cnt[1], 32);

        // Contention: both continuously re-request reads.
        glog.delete();
        fork
            begin repeat (2) do_op(0, 1'b0, 5'd3, 8'h00); end
            begin repeat (2) do_op(1, 1'b0, 5'd4, 8'h00); end
        join
        wait_idle();
        chk("contention_count", glog.size(), 4);
        for (int i = 1; i < glog.size(); i++) chk("alternate", glog[i], 1 - glog[i-1]);

        // Reset while a read is in RDCAP.
        do_op(0, 1'b0, 5'd7, 8'h00);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_mid_read", outs, 36'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        glog.delete();
        fork
            do_op(0, 1'b0, 5'd3, 8'h00);
            do_op(1, 1'b0, 5'd9, 8'h00);
        join
        wait_idle();
        chk("post_reset_first", glog[0], 0);

        // Write and competing read of the same address.
        glog.delete();
        fork
            do_op(0, 1'b1, 5'd31, 8'hFF);
            do_op(1, 1'b0, 5'd31, 8'h00);
        join
        wait_idle();
        chk("mixed_order", {glog[0], glog[1]}, {32'd0, 32'd1});
        chk("mixed_rdata", rdata1, 8'hFF);

        // Random traffic from both requesters.
        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
                do_op(0, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), 8'($urandom_range(255, 0)));
            end
            for (int j = 0; j < 40; j++) begin
                repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
                do_op(1, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), 8'($urandom_range(255, 0)));
            end
        join
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
